// File: rtl/tx_bit_controller.sv
// Bit-level transmit sequencer: SYNC, LSB-first payload with bit stuffing, then a two-period SE0 EOP and one J period.
// Produces the raw bit stream plus the bit-period strobes that clock a downstream NRZI encoder.
module tx_bit_controller #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_orig,
    output logic       strobe,
    output logic       strobe_middle,
    output logic       eop,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [2:0] fsm_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SYNC    = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_STUFF   = 3'd3;
    localparam logic [2:0] ST_EOP_SE0 = 3'd4;
    localparam logic [2:0] ST_EOP_J   = 3'd5;

    logic [2:0]    state, state_nxt;
    logic [CW-1:0] bit_cnt, cnt_nxt;
    logic [2:0]    bit_idx, idx_nxt;
    logic [2:0]    ones_cnt, ones_nxt;
    logic [7:0]    shift_reg, shift_nxt;
    logic          cur_last, cur_last_nxt;
    logic [7:0]    buf_data, buf_data_nxt;
    logic          buf_last, buf_last_nxt;
    logic          buf_full, buf_full_nxt;
    logic          last_seen, last_seen_nxt;
    logic          stuff_at_end, stuff_end_nxt;
    logic          err_seen, err_seen_nxt;

    logic [2:0]    ones_run;
    logic          need_stuff;
    logic          at_boundary;
    logic          shifting_state;

    assign fsm_state = state;
    assign tx_busy   = (state != ST_IDLE);
    assign eop       = (state == ST_EOP_SE0);

    assign strobe        = (state != ST_IDLE) && (bit_cnt == CNT_LAST);
    assign strobe_middle = (state != ST_IDLE) && (bit_cnt == CNT_MID);

    always_comb begin
        d_orig = 1'b1;
        case (state)
            ST_SYNC:  d_orig = (bit_idx == 3'd7);
            ST_DATA:  d_orig = shift_reg[0];
            ST_STUFF: d_orig = 1'b0;
            default:  d_orig = 1'b1;
        endcase
    end

    // Handshake: a byte moves into the holding buffer on a rising edge where
    // tx_valid && tx_ready; tx_ready never depends on tx_valid, and the
    // producer must hold tx_data/tx_last stable while tx_valid is high.
    assign tx_ready = !buf_full && !last_seen &&
                      ((state == ST_SYNC) || (state == ST_DATA) || (state == ST_STUFF));

    assign shifting_state = (state == ST_SYNC) || (state == ST_DATA);
    assign ones_run   = d_orig ? (ones_cnt + 3'd1) : 3'd0;
    assign need_stuff = shifting_state && (ones_run == 3'd6);

    // A byte boundary is the end of SYNC bit 7 or data bit 7, deferred past a trailing stuff bit.
    assign at_boundary = strobe &&
                         ((shifting_state && !need_stuff && (bit_idx == 3'd7)) ||
                          ((state == ST_STUFF) && stuff_at_end));

    assign tx_error = at_boundary && !cur_last && !buf_full;
    assign tx_done  = (state == ST_EOP_J) && strobe && !err_seen;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = bit_cnt;
        idx_nxt       = bit_idx;
        ones_nxt      = ones_cnt;
        shift_nxt     = shift_reg;
        cur_last_nxt  = cur_last;
        buf_data_nxt  = buf_data;
        buf_last_nxt  = buf_last;
        buf_full_nxt  = buf_full;
        last_seen_nxt = last_seen;
        stuff_end_nxt = stuff_at_end;
        err_seen_nxt  = err_seen;

        if (state != ST_IDLE) begin
            cnt_nxt = strobe ? '0 : bit_cnt + 1'b1;
        end

        if (tx_valid && tx_ready) begin
            buf_data_nxt = tx_data;
            buf_last_nxt = tx_last;
            buf_full_nxt = 1'b1;
            if (tx_last) begin
                last_seen_nxt = 1'b1;
            end
        end

        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    state_nxt     = ST_SYNC;
                    cnt_nxt       = '0;
                    idx_nxt       = 3'd0;
                    ones_nxt      = 3'd0;
                    cur_last_nxt  = 1'b0;
                    last_seen_nxt = 1'b0;
                    err_seen_nxt  = 1'b0;
                    stuff_end_nxt = 1'b0;
                    buf_full_nxt  = 1'b0;
                end
            end
            ST_SYNC, ST_DATA: begin
                if (strobe) begin
                    ones_nxt = ones_run;
                    idx_nxt  = bit_idx + 3'd1;
                    if (state == ST_DATA) begin
                        shift_nxt = {1'b0, shift_reg[7:1]};
                    end
                    if (need_stuff) begin
                        state_nxt     = ST_STUFF;
                        stuff_end_nxt = (bit_idx == 3'd7);
                        ones_nxt      = 3'd0;
                    end
                end
            end
            ST_STUFF: begin
                if (strobe) begin
                    ones_nxt = 3'd0;
                    if (!stuff_at_end) begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_EOP_SE0: begin
                if (strobe) begin
                    idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd1) begin
                        state_nxt = ST_EOP_J;
                        idx_nxt   = 3'd0;
                    end
                end
            end
            ST_EOP_J: begin
                if (strobe) begin
                    state_nxt     = ST_IDLE;
                    cnt_nxt       = '0;
                    buf_full_nxt  = 1'b0;
                    last_seen_nxt = 1'b0;
                    err_seen_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Boundary decision overrides the per-state defaults above.
        if (at_boundary) begin
            idx_nxt = 3'd0;
            if (cur_last) begin
                state_nxt = ST_EOP_SE0;
            end else if (buf_full) begin
                shift_nxt    = buf_data;
                cur_last_nxt = buf_last;
                buf_full_nxt = 1'b0;
                state_nxt    = ST_DATA;
            end else begin
                err_seen_nxt = 1'b1;
                state_nxt    = ST_EOP_SE0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            bit_idx      <= 3'd0;
            ones_cnt     <= 3'd0;
            shift_reg    <= 8'h00;
            cur_last     <= 1'b0;
            buf_data     <= 8'h00;
            buf_last     <= 1'b0;
            buf_full     <= 1'b0;
            last_seen    <= 1'b0;
            stuff_at_end <= 1'b0;
            err_seen     <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= cnt_nxt;
            bit_idx      <= idx_nxt;
            ones_cnt     <= ones_nxt;
            shift_reg    <= shift_nxt;
            cur_last     <= cur_last_nxt;
            buf_data     <= buf_data_nxt;
            buf_last     <= buf_last_nxt;
            buf_full     <= buf_full_nxt;
            last_seen    <= last_seen_nxt;
            stuff_at_end <= stuff_end_nxt;
            err_seen     <= err_seen_nxt;
        end
    end

endmodule
